// File: rtl/lagrange_coef_gen_if.sv
// Coefficient-generator handshake: start/mu request in, busy/valid status and the
// double-buffered h0..h5 coefficient bank out.
interface lagrange_coef_gen_if #(
    parameter int MU_W   = 10,
    parameter int COEF_W = 11
);
    logic                     start;
    logic [MU_W-1:0]          mu_in;
    logic                     busy;
    logic                     coef_valid;
    logic [MU_W-1:0]          mu_active;
    logic signed [COEF_W-1:0] h0;
    logic signed [COEF_W-1:0] h1;
    logic signed [COEF_W-1:0] h2;
    logic signed [COEF_W-1:0] h3;
    logic signed [COEF_W-1:0] h4;
    logic signed [COEF_W-1:0] h5;

    modport master (
        output start, mu_in,
        input  busy, coef_valid, mu_active, h0, h1, h2, h3, h4, h5
    );

    modport slave (
        input  start, mu_in,
        output busy, coef_valid, mu_active, h0, h1, h2, h3, h4, h5
    );
endinterface

// File: rtl/lagrange_coef_gen.sv
// 6-tap Lagrange fractional-delay coefficient generator (D = 2 + mu), one shared
// multiplier, results collected in a shadow bank and published atomically.
module lagrange_coef_gen #(
    parameter int MU_W   = 10,
    parameter int COEF_W = 11,
    parameter int P_W    = 24
) (
    input logic                clk,
    input logic                reset,
    lagrange_coef_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, SCALE, DONE} state_t;

    localparam logic signed [P_W+13:0] SAT_HI = (P_W+14)'((2 ** (COEF_W - 1)) - 1);
    localparam logic signed [P_W+13:0] SAT_LO = -SAT_HI - (P_W+14)'(1);

    state_t                   state;
    logic [2:0]               k;
    logic [2:0]               j;
    logic [2:0]               m;
    logic signed [12:0]       dq;
    logic [MU_W-1:0]          mu_lat;
    logic signed [P_W-1:0]    p;
    logic signed [COEF_W-1:0] shadow [6];

    logic [MU_W+9:0]          mu_ext;
    logic [9:0]               mu_q10;
    logic signed [13:0]       fac_w;
    logic signed [12:0]       factor;
    logic signed [P_W+12:0]   prod_mul;
    logic signed [P_W+13:0]   prod_scl;
    logic signed [P_W+13:0]   rnd_scl;
    logic signed [COEF_W-1:0] h_scl;

    // Q16 reciprocals of prod_{m!=k} (k - m)
    function automatic logic signed [13:0] recip(input logic [2:0] idx);
        case (idx)
            3'd0:    return -14'sd546;
            3'd1:    return 14'sd2731;
            3'd2:    return -14'sd5461;
            3'd3:    return 14'sd5461;
            3'd4:    return -14'sd2731;
            default: return 14'sd546;
        endcase
    endfunction

    function automatic logic signed [COEF_W-1:0] sat(input logic signed [P_W+13:0] v);
        if (v > SAT_HI)      return {1'b0, {(COEF_W-1){1'b1}}};
        else if (v < SAT_LO) return {1'b1, {(COEF_W-1){1'b0}}};
        else                 return v[COEF_W-1:0];
    endfunction

    // Top 10 bits of {mu, 10'b0} give mu in Q10 for any MU_W, truncating
    assign mu_ext   = {bus.mu_in, 10'b0};
    assign mu_q10   = mu_ext[MU_W+9 -: 10];

    // Factor index j walks m = 0..5 skipping m == k
    assign m        = (j >= k) ? j + 3'd1 : j;
    assign fac_w    = {dq[12], dq} - $signed({1'b0, m, 10'b0});
    assign factor   = fac_w[12:0];
    assign prod_mul = (P_W+13)'(p) * (P_W+13)'(factor);
    assign prod_scl = (P_W+14)'(p) * (P_W+14)'(recip(k));
    assign rnd_scl  = prod_scl + (P_W+14)'(32768);
    assign h_scl    = sat(rnd_scl >>> 16);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            k              <= '0;
            j              <= '0;
            dq             <= '0;
            mu_lat         <= '0;
            p              <= '0;
            for (int i = 0; i < 6; i++) shadow[i] <= '0;
            bus.busy       <= 1'b0;
            bus.coef_valid <= 1'b0;
            bus.mu_active  <= '0;
            bus.h0         <= '0;
            bus.h1         <= '0;
            bus.h2         <= '0;
            bus.h3         <= '0;
            bus.h4         <= '0;
            bus.h5         <= '0;
        end else begin
            bus.coef_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dq       <= {3'b010, mu_q10};
                        mu_lat   <= bus.mu_in;
                        k        <= '0;
                        j        <= '0;
                        p        <= P_W'(1024);
                        bus.busy <= 1'b1;
                        state    <= MUL;
                    end
                end
                // Floor-scaled running product, five factors per coefficient
                MUL: begin
                    p <= $signed(prod_mul[P_W+9:10]);
                    if (j == 3'd4) begin
                        j     <= '0;
                        state <= SCALE;
                    end else begin
                        j <= j + 3'd1;
                    end
                end
                SCALE: begin
                    shadow[k] <= h_scl;
                    if (k == 3'd5) begin
                        state <= DONE;
                    end else begin
                        k     <= k + 3'd1;
                        p     <= P_W'(1024);
                        j     <= '0;
                        state <= MUL;
                    end
                end
                // Publish the whole bank in one edge
                DONE: begin
                    bus.h0         <= shadow[0];
                    bus.h1         <= shadow[1];
                    bus.h2         <= shadow[2];
                    bus.h3         <= shadow[3];
                    bus.h4         <= shadow[4];
                    bus.h5         <= shadow[5];
                    bus.mu_active  <= mu_lat;
                    bus.coef_valid <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lagrange_coef_gen.sv
// Scoreboard bench for lagrange_coef_gen: directed cases, reset abort, sweep and
// randomized runs checked against a loop-based reference of the Lagrange algorithm.
module tb_lagrange_coef_gen;
    localparam int MU_W   = 10;
    localparam int COEF_W = 11;
    localparam int P_W    = 24;

    typedef logic [5:0][COEF_W-1:0] hvec_t;
    typedef struct packed {
        hvec_t           h;
        logic [MU_W-1:0] mu;
        logic [31:0]     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t e_mon;
    hvec_t h_case1, h_case2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lagrange_coef_gen_if #(.MU_W(MU_W), .COEF_W(COEF_W)) bus();

    lagrange_coef_gen #(.MU_W(MU_W), .COEF_W(COEF_W), .P_W(P_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int dut_h(input int i);
        case (i)
            0:       return int'(bus.h0);
            1:       return int'(bus.h1);
            2:       return int'(bus.h2);
            3:       return int'(bus.h3);
            4:       return int'(bus.h4);
            default: return int'(bus.h5);
        endcase
    endfunction

    function automatic longint recip_q16(input int k);
        case (k)
            0:       return -546;
            1:       return 2731;
            2:       return -5461;
            3:       return 5461;
            4:       return -2731;
            default: return 546;
        endcase
    endfunction

    // h_k = prod_{m!=k} (D - m) / (k - m), with the fixed-point rounding of the algorithm
    function automatic hvec_t model(input int mu);
        hvec_t  res;
        longint p, v;
        longint dq = 2048 + longint'(mu);
        for (int k = 0; k < 6; k++) begin
            p = 1024;
            for (int mm = 0; mm < 6; mm++)
                if (mm != k) p = (p * (dq - longint'(mm) * 1024)) >>> 10;
            v = (p * recip_q16(k) + 32768) >>> 16;
            if (v > 1023)  v = 1023;
            if (v < -1024) v = -1024;
            res[k] = v[COEF_W-1:0];
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int mu, input hvec_t hexp);
        int guard = 0;
        while (bus.busy && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("issue_wait_timeout", guard, 0);
        bus.start = 1'b1;
        bus.mu_in = MU_W'(mu);
        exp_q.push_back('{h: hexp, mu: MU_W'(mu), cyc: 32'(cyc + 38)});
        tick();
        bus.start = 1'b0;
        bus.mu_in = MU_W'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            tick();
            guard++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.coef_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_coef_valid", 1, 0);
            end else begin
                e_mon = exp_q.pop_front();
                check("latency", cyc, int'(e_mon.cyc));
                for (int i = 0; i < 6; i++)
                    check($sformatf("h%0d_mu%0d", i, e_mon.mu), dut_h(i), int'($signed(e_mon.h[i])));
                check("mu_active", int'(bus.mu_active), int'(e_mon.mu));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism, sum, r, guard;
        h_case1[0] = COEF_W'(12);   h_case1[1] = COEF_W'(-100); h_case1[2] = COEF_W'(600);
        h_case1[3] = COEF_W'(600);  h_case1[4] = COEF_W'(-100); h_case1[5] = COEF_W'(12);
        h_case2 = '0;
        h_case2[2] = COEF_W'(1023);

        reset = 1'b1;
        bus.start = 1'b0;
        bus.mu_in = '0;
        repeat (3) tick();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.coef_valid), 0);
        check("rst_mu_active", int'(bus.mu_active), 0);
        for (int i = 0; i < 6; i++) check($sformatf("rst_h%0d", i), dut_h(i), 0);
        reset = 1'b0;
        tick();

        // Case 1: mu = 0.5
        issue(512, h_case1);
        check("busy_after_start", int'(bus.busy), 1);
        drain();
        check("busy_after_done", int'(bus.busy), 0);
        check("valid_one_cycle", int'(bus.coef_valid), 0);

        // Case 2: mu = 0, h2 saturates
        issue(0, h_case2);
        drain();

        // Case 3: mu = 0.25
        issue(256, model(256));
        drain();
        check("case3_h0", dut_h(0), 10);
        check("case3_h2", dut_h(2), 866);
        sum = 0;
        for (int i = 0; i < 6; i++) sum += dut_h(i);
        check("case3_sum_near_unity", int'(sum >= 1018 && sum <= 1030), 1);

        // Case 4: start while busy ignored, then back-to-back start in the valid cycle
        issue(512, h_case1);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.mu_in = '0;
        tick();
        bus.start = 1'b0;
        check("busy_during_ignored_start", int'(bus.busy), 1);
        guard = 0;
        while (!bus.coef_valid && guard < 100) begin
            tick();
            guard++;
        end
        check("case4_valid_seen", int'(bus.coef_valid), 1);
        issue(0, h_case2);
        drain();

        // Case 5: outputs hold during a run, reset aborts it
        issue(512, h_case1);
        drain();
        issue(0, h_case2);
        for (int c = 1; c < 20; c++) begin
            mism = 0;
            for (int i = 0; i < 6; i++)
                if (dut_h(i) != int'($signed(h_case1[i]))) mism++;
            check($sformatf("hold_c%0d_mismatches", c), mism, 0);
            tick();
        end
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("abort_busy", int'(bus.busy), 0);
        check("abort_valid", int'(bus.coef_valid), 0);
        check("abort_mu_active", int'(bus.mu_active), 0);
        for (int i = 0; i < 6; i++) check($sformatf("abort_h%0d", i), dut_h(i), 0);
        reset = 1'b0;
        repeat (45) tick();

        // Case 6: sweep
        for (int mu = 0; mu < 1024; mu += 31) issue(mu, model(mu));
        drain();

        // Randomized runs with gaps and ignored starts
        for (int n = 0; n < 20; n++) begin
            r = int'($urandom_range(0, 1023));
            issue(r, model(r));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 30)) tick();
                check("busy_at_random_ignored_start", int'(bus.busy), 1);
                bus.start = 1'b1;
                bus.mu_in = MU_W'($urandom);
                tick();
                bus.start = 1'b0;
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
